// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Shares one async_transmitter among N_REQ byte-stream
//               requesters. Packets are arbitrated round-robin, optionally
//               prefixed with a channel-ID header byte, and pushed through
//               the transmitter's start/busy handshake one byte at a time.
//               A granted requester that stalls mid-packet for GAP_TIMEOUT
//               cycles is released with an abort pulse.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               req_valid_i     - per-requester byte valid
//               req_data_i      - per-requester byte, requester i at [8i+7:8i]
//               req_last_i      - marks the final byte of a packet
//               req_ready_o     - combinational accept strobe per requester
//               tx_start_o      - one-cycle start pulse to the transmitter
//               tx_data_o       - byte to the transmitter
//               tx_busy_i       - transmitter busy
//               grant_o         - one-hot current owner, 0 when idle
//               pkt_done_o      - pulse after a packet's last byte completes
//               abort_o         - pulse on gap timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int         N_REQ       = 4,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] ID_BASE     = 8'hA0,
  parameter int         GAP_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 pkt_done_o,
  output logic                 abort_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = IW + 1;
  localparam int CW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT + 1) : 1;

  localparam logic [CW-1:0]    GAP_LAST = CW'(GAP_TIMEOUT);
  localparam logic [IW-1:0]    RR_INIT  = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WHI   = 3'd3;
  localparam logic [2:0] ST_WLO   = 3'd4;

  logic [2:0]       state_q,    state_d;
  logic [N_REQ-1:0] grant_q,    grant_d;
  logic [IW-1:0]    idx_q,      idx_d;
  logic [IW-1:0]    rr_ptr_q,   rr_ptr_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             last_q,     last_d;
  logic             hdr_q,      hdr_d;
  logic             pkt_done_q, pkt_done_d;
  logic             abort_q,    abort_d;
  logic [CW-1:0]    gap_q,      gap_d;

  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [SW-1:0]    w_sum;
  logic             w_sel_valid;
  logic [7:0]       w_sel_data;

  assign w_sel_valid = req_valid_i[idx_q];
  assign w_sel_data  = req_data_i[{idx_q, 3'b000} +: 8];

  // Round-robin search starting just after rr_ptr. The loop walks offsets
  // from farthest to nearest so the nearest valid requester is the one left
  // in w_pick. The sum is at most 2*N_REQ-1, so one conditional subtract
  // performs the modulo.
  always_comb begin
    w_found = 1'b0;
    w_pick  = rr_ptr_q;
    w_sum   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      w_sum = {1'b0, rr_ptr_q} + SW'(off);
      if (w_sum >= SW'(N_REQ)) begin
        w_sum = w_sum - SW'(N_REQ);
      end
      if (req_valid_i[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  // Only the grantee can be accepted, and only in the data-issue state while
  // the transmitter is free.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_DATA && !tx_busy_i) begin
      req_ready_o[idx_q] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    hdr_d      = hdr_q;
    pkt_done_d = 1'b0;
    abort_d    = 1'b0;
    gap_d      = gap_q;

    case (state_q)
      ST_IDLE: begin
        // Waiting for tx_busy low also protects a frame still in flight
        // after a mid-operation reset.
        if (w_found && !tx_busy_i) begin
          grant_d = ONE_HOT0 << w_pick;
          idx_d   = w_pick;
          gap_d   = '0;
          state_d = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
        end
      end

      ST_HDR: begin
        tx_start_d = 1'b1;
        tx_data_d  = ID_BASE + 8'(idx_q);
        hdr_d      = 1'b1;
        state_d    = ST_WHI;
      end

      ST_DATA: begin
        if (w_sel_valid) begin
          if (!tx_busy_i) begin
            tx_start_d = 1'b1;
            tx_data_d  = w_sel_data;
            last_d     = req_last_i[idx_q];
            hdr_d      = 1'b0;
            gap_d      = '0;
            state_d    = ST_WHI;
          end
        end else if (GAP_TIMEOUT != 0) begin
          if (gap_q + CW'(1) == GAP_LAST) begin
            abort_d  = 1'b1;
            rr_ptr_d = idx_q;
            grant_d  = '0;
            gap_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            gap_d = gap_q + CW'(1);
          end
        end
      end

      ST_WHI: begin
        // The transmitter raises busy the cycle after it sees tx_start.
        if (tx_busy_i) begin
          state_d = ST_WLO;
        end
      end

      ST_WLO: begin
        if (!tx_busy_i) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = ST_DATA;
          end else if (last_q) begin
            pkt_done_d = 1'b1;
            rr_ptr_d   = idx_q;
            grant_d    = '0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= RR_INIT;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      last_q     <= 1'b0;
      hdr_q      <= 1'b0;
      pkt_done_q <= 1'b0;
      abort_q    <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      hdr_q      <= hdr_d;
      pkt_done_q <= pkt_done_d;
      abort_q    <= abort_d;
      gap_q      <= gap_d;
    end
  end

  assign grant_o    = grant_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign pkt_done_o = pkt_done_q;
  assign abort_o    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Testbench for uart_tx_scheduler. Instance A has headers and a
//               16-cycle gap timeout; instance B has no header and no timeout.
//               A behavioural transmitter model drives tx_busy for each.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;
  localparam int         N    = 4;
  localparam logic [7:0] A_ID = 8'hA0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_len = 4;

  // ---------------- instance A ----------------
  logic [N-1:0]   a_valid = '0, a_last = '0;
  logic [8*N-1:0] a_data  = '0;
  logic [N-1:0]   a_ready, a_grant;
  logic           a_start, a_done, a_abort;
  logic [7:0]     a_txd;
  logic           a_busy = 1'b0;

  uart_tx_scheduler #(.N_REQ(N), .HEADER_EN(1), .ID_BASE(A_ID), .GAP_TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(a_valid), .req_data_i(a_data), .req_last_i(a_last),
    .req_ready_o(a_ready), .tx_start_o(a_start), .tx_data_o(a_txd),
    .tx_busy_i(a_busy), .grant_o(a_grant), .pkt_done_o(a_done), .abort_o(a_abort)
  );

  // ---------------- instance B ----------------
  logic [N-1:0]   b_valid = '0, b_last = '0;
  logic [8*N-1:0] b_data  = '0;
  logic [N-1:0]   b_ready, b_grant;
  logic           b_start, b_done, b_abort;
  logic [7:0]     b_txd;
  logic           b_busy = 1'b0;

  uart_tx_scheduler #(.N_REQ(N), .HEADER_EN(0), .ID_BASE(A_ID), .GAP_TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(b_valid), .req_data_i(b_data), .req_last_i(b_last),
    .req_ready_o(b_ready), .tx_start_o(b_start), .tx_data_o(b_txd),
    .tx_busy_i(b_busy), .grant_o(b_grant), .pkt_done_o(b_done), .abort_o(b_abort)
  );

  // Transmitter models: busy rises the edge after tx_start and stays high
  // for frame_len cycles. They ignore rst, like a real transmitter would.
  int cnt_a = 0, cnt_b = 0;
  always @(posedge clk) begin
    if (a_start && !a_busy) begin cnt_a = frame_len; a_busy <= 1'b1; end
    else if (cnt_a > 1) cnt_a--;
    else if (cnt_a == 1) begin cnt_a = 0; a_busy <= 1'b0; end
  end
  always @(posedge clk) begin
    if (b_start && !b_busy) begin cnt_b = frame_len; b_busy <= 1'b1; end
    else if (cnt_b > 1) cnt_b--;
    else if (cnt_b == 1) begin cnt_b = 0; b_busy <= 1'b0; end
  end

  // Monitors
  logic [7:0] obs_a[$];
  logic [7:0] obs_b[$];
  int glog[$];
  int pkt_a = 0, abort_a = 0, pkt_b = 0;
  int v_start = 0, v_width = 0, v_ready = 0, v_excl = 0, v_onehot = 0;
  logic prev_start = 1'b0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (a_start) obs_a.push_back(a_txd);
    if (a_start && a_busy) v_start++;
    if (a_start && prev_start) v_width++;
    if (a_busy && a_ready != '0) v_ready++;
    if (a_done) pkt_a++;
    if (a_abort) abort_a++;
    if (a_done && a_abort) v_excl++;
    if ($countones(a_grant) > 1) v_onehot++;
    if (a_grant != '0 && a_grant != prev_grant)
      for (int i = 0; i < N; i++) if (a_grant[i]) glog.push_back(i);
    prev_start = a_start;
    prev_grant = a_grant;
    if (b_start) obs_b.push_back(b_txd);
    if (b_done) pkt_b++;
  end

  // Packet source queues and reference model outputs
  logic [7:0] pq_data[N][$];
  bit         pq_last[N][$];
  logic [7:0] exp_q[$];
  int         exp_g[$];
  int         exp_npk;

  task automatic do_reset();
    rst = 1'b1;
    a_valid = '0; a_last = '0; b_valid = '0; b_last = '0;
    for (int c = 0; c < 500 && (a_busy || b_busy); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Reference: at each idle point every requester with packets left is
  // requesting; pick the first after the last owner, emit header + bytes.
  task automatic build_model();
    int pos[N];
    int ptr, found, j;
    bit lst;
    exp_q.delete(); exp_g.delete(); exp_npk = 0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    ptr = N - 1;
    for (int guard = 0; guard < 1000; guard++) begin
      found = -1;
      for (int off = 1; off <= N; off++) begin
        j = (ptr + off) % N;
        if (found < 0 && pos[j] < pq_data[j].size()) found = j;
      end
      if (found < 0) break;
      exp_g.push_back(found);
      exp_q.push_back(A_ID + 8'(found));
      lst = 1'b0;
      while (!lst && pos[found] < pq_data[found].size()) begin
        exp_q.push_back(pq_data[found][pos[found]]);
        lst = pq_last[found][pos[found]];
        pos[found]++;
      end
      exp_npk++;
      ptr = found;
    end
  endtask

  task automatic run_traffic(input bit gaps, input string name);
    bit pend[N];
    bit inpkt[N];
    bit done;
    int b_obs, b_pkt, b_abort, b_glog, b_vs, b_vw, b_vr, b_ve, b_vo;
    build_model();
    b_obs = obs_a.size(); b_pkt = pkt_a; b_abort = abort_a; b_glog = glog.size();
    b_vs = v_start; b_vw = v_width; b_vr = v_ready; b_ve = v_excl; b_vo = v_onehot;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; inpkt[i] = 1'b0; end
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (pend[i]) begin
        inpkt[i] = !pq_last[i][0];
        void'(pq_data[i].pop_front());
        void'(pq_last[i].pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (pq_data[i].size() > 0) begin
          a_valid[i] = !(gaps && inpkt[i] && $urandom_range(3) == 0);
          a_data[8*i +: 8] = pq_data[i][0];
          a_last[i] = pq_last[i][0];
        end else begin
          a_valid[i] = 1'b0;
          a_last[i]  = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < N; i++) pend[i] = a_valid[i] & a_ready[i];
      done = (pkt_a - b_pkt == exp_npk) && !a_busy;
      for (int i = 0; i < N; i++) if (pq_data[i].size() > 0) done = 1'b0;
    end
    a_valid = '0;
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL %s timeout: pkts %0d, required %0d", name, pkt_a - b_pkt, exp_npk); end
    n_tests++;
    if (obs_a.size() - b_obs !== exp_q.size()) begin
      n_fail++; $display("FAIL %s byte count: got %0d, required %0d", name, obs_a.size() - b_obs, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) if (b_obs + k < obs_a.size()) begin
      n_tests++;
      if (obs_a[b_obs + k] !== exp_q[k]) begin
        n_fail++; $display("FAIL %s byte %0d: got %h, required %h", name, k, obs_a[b_obs + k], exp_q[k]);
      end
    end
    n_tests++;
    if (glog.size() - b_glog !== exp_g.size()) begin
      n_fail++; $display("FAIL %s grant count: got %0d, required %0d", name, glog.size() - b_glog, exp_g.size());
    end
    for (int k = 0; k < exp_g.size(); k++) if (b_glog + k < glog.size()) begin
      n_tests++;
      if (glog[b_glog + k] !== exp_g[k]) begin
        n_fail++; $display("FAIL %s grant %0d: got %0d, required %0d", name, k, glog[b_glog + k], exp_g[k]);
      end
    end
    n_tests++;
    if (pkt_a - b_pkt !== exp_npk) begin n_fail++; $display("FAIL %s pkt_done: got %0d, required %0d", name, pkt_a - b_pkt, exp_npk); end
    n_tests++;
    if (abort_a - b_abort !== 0) begin n_fail++; $display("FAIL %s abort: got %0d, required 0", name, abort_a - b_abort); end
    n_tests++;
    if (v_start - b_vs !== 0 || v_width - b_vw !== 0) begin
      n_fail++; $display("FAIL %s tx_start: busy-overlap %0d wide %0d, required 0 0", name, v_start - b_vs, v_width - b_vw);
    end
    n_tests++;
    if (v_ready - b_vr !== 0) begin n_fail++; $display("FAIL %s ready_while_busy: got %0d, required 0", name, v_ready - b_vr); end
    n_tests++;
    if (v_excl - b_ve !== 0 || v_onehot - b_vo !== 0) begin
      n_fail++; $display("FAIL %s excl/onehot: got %0d/%0d, required 0/0", name, v_excl - b_ve, v_onehot - b_vo);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin pq_data[i].delete(); pq_last[i].delete(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (a_grant !== '0) begin n_fail++; $display("FAIL reset grant: got %b, required 0", a_grant); end
    n_tests++; if (a_start !== 1'b0) begin n_fail++; $display("FAIL reset tx_start: got %b, required 0", a_start); end
    n_tests++; if (a_txd !== 8'h00) begin n_fail++; $display("FAIL reset tx_data: got %h, required 00", a_txd); end
    n_tests++; if (a_done !== 1'b0 || a_abort !== 1'b0) begin n_fail++; $display("FAIL reset pulses: got %b%b, required 00", a_done, a_abort); end
    n_tests++; if (a_ready !== '0) begin n_fail++; $display("FAIL reset req_ready: got %b, required 0", a_ready); end
    do_reset();
  endtask

  task automatic test_single_packet();
    do_reset(); frame_len = 4; clear_queues();
    pq_data[1].push_back(8'h11); pq_last[1].push_back(1'b0);
    pq_data[1].push_back(8'h22); pq_last[1].push_back(1'b1);
    run_traffic(1'b0, "single_packet");
  endtask

  task automatic test_round_robin();
    do_reset(); frame_len = 3; clear_queues();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        pq_data[i].push_back(8'($urandom)); pq_last[i].push_back(1'b1);
      end
    run_traffic(1'b0, "round_robin");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      do_reset(); frame_len = $urandom_range(2, 6); clear_queues();
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            pq_data[i].push_back(8'($urandom)); pq_last[i].push_back(b == nb - 1);
          end
        end
      end
      run_traffic(1'b1, "random");
    end
  endtask

  task automatic test_slow_tx();
    do_reset(); frame_len = 100; clear_queues();
    pq_data[0].push_back(8'h3C); pq_last[0].push_back(1'b0);
    pq_data[0].push_back(8'hC3); pq_last[0].push_back(1'b1);
    pq_data[2].push_back(8'h5A); pq_last[2].push_back(1'b1);
    run_traffic(1'b0, "slow_tx");
    frame_len = 4;
  endtask

  task automatic test_gap_timeout();
    bit acc, rdy, got, done, pend3;
    int n, b_obs, b_pkt, b_abort, b_glog;
    logic [7:0] exp_s[4];
    int exp_gr[2];
    exp_s[0] = 8'hA2; exp_s[1] = 8'h5A; exp_s[2] = 8'hA3; exp_s[3] = 8'h77;
    exp_gr[0] = 2; exp_gr[1] = 3;
    do_reset(); frame_len = 4;
    b_obs = obs_a.size(); b_pkt = pkt_a; b_abort = abort_a; b_glog = glog.size();
    a_valid[2] = 1'b1; a_data[23:16] = 8'h5A; a_last[2] = 1'b0;
    a_valid[3] = 1'b1; a_data[31:24] = 8'h77; a_last[3] = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk); #1;
      if (a_valid[2] && a_ready[2]) acc = 1'b1;
    end
    @(negedge clk); a_valid[2] = 1'b0;
    rdy = 1'b0;
    for (int c = 0; c < 200 && !rdy; c++) begin
      @(negedge clk); #1;
      if (a_ready[2]) rdy = 1'b1;
    end
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      if (a_abort) got = 1'b1;
      else begin @(negedge clk); #1; n++; end
    end
    n_tests++; if (!acc || !rdy) begin n_fail++; $display("FAIL gap setup: accepted %0b reentered %0b, required 1 1", acc, rdy); end
    n_tests++; if (n !== 16) begin n_fail++; $display("FAIL gap abort_delay: got %0d, required 16", n); end
    pend3 = 1'b0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (pend3) a_valid[3] = 1'b0;
      #1;
      pend3 = a_valid[3] & a_ready[3];
      done = (pkt_a - b_pkt == 1) && !a_busy;
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL gap follow_pkt: pkts %0d, required 1", pkt_a - b_pkt); end
    n_tests++; if (abort_a - b_abort !== 1) begin n_fail++; $display("FAIL gap abort_count: got %0d, required 1", abort_a - b_abort); end
    n_tests++; if (obs_a.size() - b_obs !== 4) begin n_fail++; $display("FAIL gap byte_count: got %0d, required 4", obs_a.size() - b_obs); end
    for (int k = 0; k < 4; k++) if (b_obs + k < obs_a.size()) begin
      n_tests++;
      if (obs_a[b_obs + k] !== exp_s[k]) begin n_fail++; $display("FAIL gap byte %0d: got %h, required %h", k, obs_a[b_obs + k], exp_s[k]); end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (b_glog + k >= glog.size()) begin n_fail++; $display("FAIL gap grant %0d: got none, required %0d", k, exp_gr[k]); end
      else if (glog[b_glog + k] !== exp_gr[k]) begin n_fail++; $display("FAIL gap grant %0d: got %0d, required %0d", k, glog[b_glog + k], exp_gr[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int bad;
    do_reset(); frame_len = 30;
    a_valid[1] = 1'b1; a_data[15:8] = 8'h33; a_last[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin @(negedge clk); if (a_start) seen = 1'b1; end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (!seen || !a_busy) begin n_fail++; $display("FAIL rstmid setup: start %0b busy %0b, required 1 1", seen, a_busy); end
    n_tests++; if (a_grant !== '0 || a_start !== 1'b0) begin n_fail++; $display("FAIL rstmid grant/start: got %b/%b, required 0/0", a_grant, a_start); end
    n_tests++; if (a_txd !== 8'h00 || a_ready !== '0) begin n_fail++; $display("FAIL rstmid data/ready: got %h/%b, required 00/0", a_txd, a_ready); end
    n_tests++; if (a_done !== 1'b0 || a_abort !== 1'b0) begin n_fail++; $display("FAIL rstmid pulses: got %b%b, required 00", a_done, a_abort); end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 100 && a_busy; c++) begin @(negedge clk); if (a_busy && a_grant != '0) bad++; end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid grant_while_busy: got %0d, required 0", bad); end
    for (int c = 0; c < 10 && a_grant == '0; c++) @(negedge clk);
    n_tests++; if (a_grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid regrant: got %b, required 0010", a_grant); end
    do_reset(); frame_len = 4;
  endtask

  task automatic test_no_header();
    int k, b_obs, b_pkt, done_sz;
    bit pend, done;
    do_reset(); frame_len = 5;
    b_obs = obs_b.size(); b_pkt = pkt_b;
    k = 0; pend = 1'b0; done = 1'b0; done_sz = -1;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (pend) k++;
      if (k < 5) begin b_valid[0] = 1'b1; b_data[7:0] = 8'(k + 1); b_last[0] = (k == 4); end
      else b_valid[0] = 1'b0;
      #1;
      pend = b_valid[0] & b_ready[0];
      if (b_done) done_sz = obs_b.size() - b_obs;
      done = (pkt_b - b_pkt == 1) && !b_busy;
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL nohdr timeout: pkts %0d, required 1", pkt_b - b_pkt); end
    n_tests++; if (obs_b.size() - b_obs !== 5) begin n_fail++; $display("FAIL nohdr byte_count: got %0d, required 5", obs_b.size() - b_obs); end
    for (int j = 0; j < 5; j++) if (b_obs + j < obs_b.size()) begin
      n_tests++;
      if (obs_b[b_obs + j] !== 8'(j + 1)) begin n_fail++; $display("FAIL nohdr byte %0d: got %h, required %h", j, obs_b[b_obs + j], 8'(j + 1)); end
    end
    n_tests++; if (done_sz !== 5) begin n_fail++; $display("FAIL nohdr done_after: got %0d bytes, required 5", done_sz); end
    n_tests++; if (b_abort !== 1'b0) begin n_fail++; $display("FAIL nohdr abort: got %b, required 0", b_abort); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_random();
    test_slow_tx();
    test_gap_timeout();
    test_reset_mid();
    test_no_header();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
